crossing_scheduler: RTL and testbench

- Sequences the level-crossing lights and arbitrates between two train tracks requesting passage.
- Each track raises a request and receives a grant while its train light is green; the road is stopped and barriers lowered around every grant.
- Sits above the light drivers: its outputs feed the road/train lamp drivers and barrier/bell unit directly.
- Round-robin between tracks, with a bounded number of consecutive train grants before the road is served again.

---
 rtl/crossing_pkg.sv | 22 ++
 rtl/crossing_scheduler_if.sv | 27 ++
 rtl/crossing_rr_arb.sv | 25 ++
 rtl/crossing_scheduler.sv | 165 ++++++++++++++++
 tb/tb_crossing_scheduler.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/crossing_pkg.sv
// Shared types and encodings for the level-crossing scheduler.
// Light codes are {red,amber,green}; crossing codes drive the barrier/bell unit.
package crossing_pkg;

  typedef enum logic [2:0] {
    ROAD_GO,
    ROAD_AMBER,
    ROAD_STOP,
    TRAIN_GO,
    TRAIN_AMBER,
    ROAD_PREP
  } state_e;

  localparam logic [2:0] RED       = 3'b100;
  localparam logic [2:0] AMBER     = 3'b010;
  localparam logic [2:0] GREEN     = 3'b001;
  localparam logic [2:0] RED_AMBER = 3'b110;

  localparam logic [1:0] OPEN   = 2'b11;
  localparam logic [1:0] CLOSED = 2'b00;

endpackage

// File: rtl/crossing_scheduler_if.sv
// Track handshake plus lamp/barrier outputs of the crossing scheduler.
// The scheduler is the slave; whoever drives requests and clears is the master.
interface crossing_scheduler_if;

  logic [1:0] train_req;
  logic [1:0] train_clear;
  logic [1:0] train_grant;
  logic [2:0] road_lights1;
  logic [2:0] road_lights2;
  logic [2:0] train_lights1;
  logic [2:0] train_lights2;
  logic [1:0] crossing_signals;
  logic       fault;

  modport master (
    output train_req, train_clear,
    input  train_grant, road_lights1, road_lights2, train_lights1,
           train_lights2, crossing_signals, fault
  );

  modport slave (
    input  train_req, train_clear,
    output train_grant, road_lights1, road_lights2, train_lights1,
           train_lights2, crossing_signals, fault
  );

endinterface

// File: rtl/crossing_rr_arb.sv
// Two-track round-robin picker. On update the pointer moves to the track
// that was not chosen, so that track wins the next contention.
module crossing_rr_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_sel_i,
  output logic       pick_o
);

  logic ptr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else if (upd_i) begin
      ptr_q <= ~upd_sel_i;
    end
  end

  // Index 0 is track 1; with a single request the requester wins outright.
  assign pick_o = (req_i == 2'b11) ? ptr_q : req_i[1];

endmodule

// File: rtl/crossing_scheduler.sv
// Level-crossing light sequencer and two-track arbiter. All outputs are
// registered and decoded from next-state so lamps change with the state.
module crossing_scheduler
  import crossing_pkg::*;
#(
  parameter int MIN_ROAD   = 8,
  parameter int AMBER      = 3,
  parameter int CLEAR      = 2,
  parameter int TRAIN_MAX  = 20,
  parameter int MAX_CONSEC = 1,
  parameter int TW         = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  crossing_scheduler_if.slave  bus
);

  localparam int CW = $clog2(MAX_CONSEC + 2);

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [CW-1:0]   consec_q, consec_d;
  logic            sel_q, sel_d;
  logic            fault_q, fault_d;

  logic [1:0]      grant_q, grant_d;
  logic [2:0]      road_q, road_d;
  logic [2:0]      tl1_q, tl1_d;
  logic [2:0]      tl2_q, tl2_d;
  logic [1:0]      xing_q, xing_d;
  logic [2:0]      sel_light;

  logic            arb_pick;
  logic            arb_upd;
  logic            arb_upd_sel;

  crossing_rr_arb u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_i     (bus.train_req),
    .upd_i     (arb_upd),
    .upd_sel_i (arb_upd_sel),
    .pick_o    (arb_pick)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    consec_d    = consec_q;
    fault_d     = fault_q;
    arb_upd     = 1'b0;
    arb_upd_sel = sel_q;
    case (state_q)
      ROAD_GO: begin
        if (timer_q >= TW'(MIN_ROAD - 1) && bus.train_req != 2'b00) begin
          state_d     = ROAD_AMBER;
          sel_d       = arb_pick;
          arb_upd     = (bus.train_req == 2'b11);
          arb_upd_sel = arb_pick;
        end
      end
      ROAD_AMBER: begin
        if (timer_q == TW'(AMBER - 1)) state_d = ROAD_STOP;
      end
      ROAD_STOP: begin
        if (timer_q == TW'(CLEAR - 1)) begin
          state_d  = TRAIN_GO;
          consec_d = consec_q + CW'(1);
        end
      end
      TRAIN_GO: begin
        // A clear arriving with the timeout wins, so no fault is raised.
        if (bus.train_clear[sel_q]) begin
          state_d = TRAIN_AMBER;
        end else if (timer_q == TW'(TRAIN_MAX - 1)) begin
          state_d = TRAIN_AMBER;
          fault_d = 1'b1;
        end
      end
      TRAIN_AMBER: begin
        if (timer_q == TW'(AMBER - 1)) begin
          // consec counts the grants of this run; MAX_CONSEC extra ones may chain.
          if (bus.train_req[~sel_q] && consec_q <= CW'(MAX_CONSEC)) begin
            state_d     = ROAD_STOP;
            sel_d       = ~sel_q;
            arb_upd     = 1'b1;
            arb_upd_sel = ~sel_q;
          end else begin
            state_d  = ROAD_PREP;
            consec_d = '0;
          end
        end
      end
      ROAD_PREP: begin
        if (timer_q == TW'(AMBER - 1)) state_d = ROAD_GO;
      end
      default: state_d = ROAD_GO;
    endcase
  end

  // Timer saturates so an idle road phase cannot wrap below MIN_ROAD.
  always_comb begin
    if (state_d != state_q) timer_d = '0;
    else if (timer_q != '1) timer_d = timer_q + TW'(1);
    else                    timer_d = timer_q;
  end

  always_comb begin
    road_d    = RED;
    sel_light = RED;
    grant_d   = 2'b00;
    xing_d    = CLOSED;
    case (state_d)
      ROAD_GO: begin
        road_d = GREEN;
        xing_d = OPEN;
      end
      ROAD_AMBER:  road_d = crossing_pkg::AMBER;
      ROAD_PREP:   road_d = RED_AMBER;
      TRAIN_GO: begin
        sel_light = GREEN;
        grant_d   = sel_d ? 2'b10 : 2'b01;
      end
      TRAIN_AMBER: sel_light = crossing_pkg::AMBER;
      default: ;
    endcase
    tl1_d = sel_d ? RED : sel_light;
    tl2_d = sel_d ? sel_light : RED;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ROAD_GO;
      timer_q  <= '0;
      consec_q <= '0;
      sel_q    <= 1'b0;
      fault_q  <= 1'b0;
      grant_q  <= 2'b00;
      road_q   <= GREEN;
      tl1_q    <= RED;
      tl2_q    <= RED;
      xing_q   <= OPEN;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      consec_q <= consec_d;
      sel_q    <= sel_d;
      fault_q  <= fault_d;
      grant_q  <= grant_d;
      road_q   <= road_d;
      tl1_q    <= tl1_d;
      tl2_q    <= tl2_d;
      xing_q   <= xing_d;
    end
  end

  assign bus.train_grant      = grant_q;
  assign bus.road_lights1     = road_q;
  assign bus.road_lights2     = road_q;
  assign bus.train_lights1    = tl1_q;
  assign bus.train_lights2    = tl2_q;
  assign bus.crossing_signals = xing_q;
  assign bus.fault            = fault_q;

endmodule

// File: tb/tb_crossing_scheduler.sv
// Directed bench for crossing_scheduler: cycle-exact lamp/grant sequences
// for idle, single request, contention, round-robin, timeout and reset.
module tb_crossing_scheduler;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  logic [15:0] IDLE, RAMB, STOP, GO1, GO2, TAMB1, TAMB2, PREP;

  crossing_scheduler_if bus ();

  crossing_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] ev(input logic [2:0] road, input logic [2:0] t1,
                                     input logic [2:0] t2, input logic [1:0] x,
                                     input logic [1:0] g);
    return {road, road, t1, t2, x, g};
  endfunction

  function automatic logic [15:0] obs();
    return {bus.road_lights1, bus.road_lights2, bus.train_lights1,
            bus.train_lights2, bus.crossing_signals, bus.train_grant};
  endfunction

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] e);
    chk(tag, obs(), e);
  endtask

  task automatic chk_fault(input string tag, input logic e);
    chk(tag, {15'b0, bus.fault}, {15'b0, e});
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk_run(input string tag, input int n, input logic [15:0] e);
    for (int i = 0; i < n; i++) begin
      chk_out(tag, e);
      step(1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    IDLE  = ev(3'b001, 3'b100, 3'b100, 2'b11, 2'b00);
    RAMB  = ev(3'b010, 3'b100, 3'b100, 2'b00, 2'b00);
    STOP  = ev(3'b100, 3'b100, 3'b100, 2'b00, 2'b00);
    GO1   = ev(3'b100, 3'b001, 3'b100, 2'b00, 2'b01);
    GO2   = ev(3'b100, 3'b100, 3'b001, 2'b00, 2'b10);
    TAMB1 = ev(3'b100, 3'b010, 3'b100, 2'b00, 2'b00);
    TAMB2 = ev(3'b100, 3'b100, 3'b010, 2'b00, 2'b00);
    PREP  = ev(3'b110, 3'b100, 3'b100, 2'b00, 2'b00);

    reset = 1'b1;
    bus.train_req   = 2'b00;
    bus.train_clear = 2'b00;
    @(negedge clk);
    chk_out("reset_values", IDLE);
    chk_fault("reset_fault", 1'b0);
    reset = 1'b0;

    // Idle road
    chk_run("idle", 50, IDLE);

    // Early request on track 1, stray clear from track 2, normal clear
    do_reset();
    step(2);
    bus.train_req = 2'b01;
    chk_run("early_wait", 6, IDLE);
    chk_run("early_amber", 3, RAMB);
    chk_run("early_stop", 2, STOP);
    chk_out("early_go", GO1);
    bus.train_req = 2'b00;
    step(1);
    bus.train_clear = 2'b10;
    chk_out("stray_clr_go", GO1);
    step(1);
    bus.train_clear = 2'b00;
    chk_run("stray_clr_ignored", 2, GO1);
    bus.train_clear = 2'b01;
    chk_out("go_before_clear", GO1);
    step(1);
    bus.train_clear = 2'b00;
    chk_run("early_tamber", 3, TAMB1);
    chk_run("early_prep", 3, PREP);
    chk_out("early_road_back", IDLE);
    chk_fault("early_no_fault", 1'b0);

    // Request withdrawn before MIN_ROAD
    do_reset();
    step(2);
    bus.train_req = 2'b01;
    step(1);
    bus.train_req = 2'b00;
    chk_run("withdraw", 18, IDLE);

    // Contention: track 1, chained track 2, then the consecutive bound
    bus.train_req = 2'b11;
    step(1);
    chk_run("cont_amber", 3, RAMB);
    chk_run("cont_stop", 2, STOP);
    chk_out("cont_go_t1", GO1);
    bus.train_clear = 2'b01;
    step(1);
    bus.train_clear = 2'b00;
    chk_run("cont_tamber1", 3, TAMB1);
    chk_run("chain_stop_no_road", 2, STOP);
    chk_out("chain_go_t2", GO2);
    bus.train_clear = 2'b10;
    step(1);
    bus.train_clear = 2'b00;
    chk_run("chain_tamber2", 3, TAMB2);
    chk_run("consec_bound_prep", 3, PREP);
    chk_run("min_road_again", 8, IDLE);

    // Round-robin: track 1 wins, then next contention goes to track 2
    chk_run("rr_amber", 3, RAMB);
    chk_run("rr_stop", 2, STOP);
    chk_out("rr_go_t1", GO1);
    bus.train_req   = 2'b01;
    bus.train_clear = 2'b01;
    step(1);
    bus.train_clear = 2'b00;
    chk_run("rr_tamber", 3, TAMB1);
    chk_run("rr_prep", 3, PREP);
    bus.train_req = 2'b11;
    chk_run("rr_wait", 8, IDLE);
    chk_run("rr_amber2", 3, RAMB);
    chk_run("rr_stop2", 2, STOP);
    bus.train_req = 2'b00;
    chk_fault("pre_timeout_fault", 1'b0);

    // Timeout on track 2
    chk_run("timeout_go", 20, GO2);
    chk_fault("timeout_fault_set", 1'b1);
    chk_run("timeout_tamber", 3, TAMB2);
    chk_run("timeout_prep", 3, PREP);
    chk_run("after_timeout_road", 5, IDLE);
    chk_fault("fault_sticky", 1'b1);

    // Clear coinciding with the timeout
    do_reset();
    chk_fault("fault_cleared", 1'b0);
    bus.train_req = 2'b01;
    chk_run("tc_wait", 8, IDLE);
    chk_run("tc_amber", 3, RAMB);
    chk_run("tc_stop", 2, STOP);
    bus.train_req = 2'b00;
    chk_run("tc_go", 19, GO1);
    chk_out("tc_go_last", GO1);
    bus.train_clear = 2'b01;
    step(1);
    bus.train_clear = 2'b00;
    chk_out("tc_tamber", TAMB1);
    chk_fault("clear_beats_timeout", 1'b0);

    // Asynchronous reset in the middle of a grant
    do_reset();
    bus.train_req = 2'b10;
    chk_run("rst_wait", 8, IDLE);
    chk_run("rst_amber", 3, RAMB);
    chk_run("rst_stop", 2, STOP);
    bus.train_req = 2'b00;
    chk_run("rst_pre_go", 2, GO2);
    reset = 1'b1;
    #1;
    chk_out("rst_async_mid_go", IDLE);
    chk_fault("rst_async_fault", 1'b0);
    #1;
    reset = 1'b0;
    step(1);
    chk_out("after_reset", IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
